// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Interface : dmem_responder_if
// Purpose   : Request/acknowledge bus between a load/store requester and the
//             multi-cycle data-memory responder.
// Revision  : 1.0 - initial release
// ============================================================================
interface dmem_responder_if #(
  parameter int DATA_W = 32
);
  logic              req_i;
  logic              we_i;
  logic [31:0]       addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              busy_o;
  logic              ack_o;
  logic [DATA_W-1:0] rdata_o;
  logic              err_o;

  // Requester side: drives the request, observes completion.
  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  busy_o, ack_o, rdata_o, err_o
  );

  // Responder side: samples the request, reports completion.
  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output busy_o, ack_o, rdata_o, err_o
  );
endinterface : dmem_responder_if
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module    : dmem_responder
// Purpose   : Multi-cycle data-memory responder. Accepts one load/store at a
//             time, waits LATENCY cycles, then commits the write or returns
//             the read word with a one-cycle ack pulse.
// Options   : `define DMEM_ERR_EN to flag misaligned (addr[1:0] != 0)
//             accesses with err_o; such accesses never write and return 0.
// Revision  : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 4   // 1..255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dmem_responder_if.slave bus
);

  localparam int           WORDS    = 2 ** ADDR_W;
  // Counter preload: reaching zero in WAIT marks the edge E_LATENCY, so a
  // LATENCY of 1 passes through WAIT for its single cycle and still acks at
  // E1, keeping the LATENCY+2 request spacing for every legal LATENCY.
  localparam logic [7:0]   CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q,   cnt_d;
  logic                we_q,    we_d;
  logic [ADDR_W-1:0]   idx_q,   idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_we;
  logic                access_bad;
  logic                unused_addr_bits;

  // Backing store; deliberately not reset.
  logic [DATA_W-1:0]   mem [0:WORDS-1];

`ifdef DMEM_ERR_EN
  logic                mis_q, mis_d;
  assign access_bad = mis_q;
`else
  assign access_bad = 1'b0;
`endif

  // High address bits always, and the byte offset in the default build,
  // take no part in the access.
  assign unused_addr_bits = ^{bus.addr_i[31:ADDR_W+2], bus.addr_i[1:0]};

  // Next-state, request capture and commit decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
`ifdef DMEM_ERR_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req_i) begin
          we_d    = bus.we_i;
          idx_d   = bus.addr_i[ADDR_W+1:2];
          wdata_d = bus.wdata_i;
          cnt_d   = CNT_LOAD;
`ifdef DMEM_ERR_EN
          mis_d   = |bus.addr_i[1:0];
`endif
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = S_ACK;
          if (access_bad) begin
            rdata_d = '0;
          end else if (we_q) begin
            mem_we  = 1'b1;
            rdata_d = '0;
          end else begin
            rdata_d = mem[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and captured-request registers; reset aborts any request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef DMEM_ERR_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef DMEM_ERR_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // Array write on entry to ACK; mem_we is low whenever reset holds IDLE.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.busy_o  = (state_q != S_IDLE);
  assign bus.ack_o   = (state_q == S_ACK);
  assign bus.rdata_o = rdata_q;
  assign bus.err_o   = access_bad & (state_q == S_ACK);

endmodule : dmem_responder
`default_nettype wire
